// File: rtl/memory_write.sv
// memory_write: 64 x 6-bit flop storage with a per-entry valid bitmap.
// A single requester starts either a write (WEN) or a clear-all (CLRMEM)
// from IDLE. Writes commit one cycle after being sampled, settle for
// HOLD_CYCLES cycles, then pulse ACK. A clear sweeps all 64 entries
// (one per cycle) and then pulses ACK. Storage is readable at any time
// through the combinational RADD -> RDATA/RVALID monitor port.
//
// Request/acknowledge semantics: WEN or CLRMEM is accepted only on a
// rising edge where the FSM is in IDLE (BUSY=0); a request seen while
// BUSY=1 is dropped, not queued. Every accepted request ends with exactly
// one single-cycle ACK pulse, after which BUSY falls with ACK. CLRMEM wins
// over a simultaneous WEN. Reset aborts any operation without an ACK.
module memory_write #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WEN,
    input  logic [5:0] ADD,
    input  logic [5:0] DIN,
    input  logic       CLRMEM,
    input  logic [5:0] RADD,
    output logic [5:0] RDATA,
    output logic       RVALID,
    output logic       BUSY,
    output logic       ACK,
    output logic [6:0] COUNT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        HOLD  = 3'd2,
        DONE  = 3'd3,
        SWEEP = 3'd4
    } state_t;

    // Last value of the settle counter before leaving HOLD.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [6:0] COUNT_MAX = 7'd64;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  lat_add;
    logic [5:0]  lat_din;
    logic [3:0]  hold_cnt;
    logic [5:0]  sweep_idx;
    logic [6:0]  count;
    logic [5:0]  mem [64];
    logic [63:0] valid;

    // State register; reset drops any in-flight operation back to IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (CLRMEM) begin
                    state_nxt = SWEEP;
                end else if (WEN) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            SWEEP: begin
                if (sweep_idx == 6'd63) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: request latch, commit, settle counter, sweep and occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lat_add   <= '0;
            lat_din   <= '0;
            hold_cnt  <= '0;
            sweep_idx <= '0;
            count     <= '0;
            valid     <= '0;
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt  <= '0;
                    sweep_idx <= '0;
                    // The latch only matters when a write is actually taken.
                    if (WEN && !CLRMEM) begin
                        lat_add <= ADD;
                        lat_din <= DIN;
                    end
                end
                WRITE: begin
                    mem[lat_add]   <= lat_din;
                    valid[lat_add] <= 1'b1;
                    hold_cnt       <= '0;
                    // Only a fresh entry grows the occupancy count.
                    if (!valid[lat_add] && (count != COUNT_MAX)) begin
                        count <= count + 7'd1;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
                SWEEP: begin
                    mem[sweep_idx]   <= '0;
                    valid[sweep_idx] <= 1'b0;
                    sweep_idx        <= sweep_idx + 6'd1;
                    if (sweep_idx == 6'd63) begin
                        count <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Monitor port reads storage directly; a commit is visible from its edge.
    always_comb begin
        RDATA  = mem[RADD];
        RVALID = valid[RADD];
    end

    // Status outputs decoded purely from registered state.
    always_comb begin
        BUSY  = (state != IDLE);
        ACK   = (state == DONE);
        COUNT = count;
    end

endmodule

// File: doc/memory_write.md
MEMORY_WRITE -- requirements
Module: memory_write

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, range 1..15: number of settle cycles after each write commit, before ACK.
REQ-002 Reset is asynchronous and active-low; the design has one clock, CLK, and the reset port is RST.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous active-low reset.
REQ-005 WEN  input  1  write request; sampled only in IDLE.
REQ-006 ADD  input  6  write address, 0..63.
REQ-007 DIN  input  6  write data.
REQ-008 CLRMEM  input  1  clear-all request; sampled only in IDLE.
REQ-009 RADD  input  6  monitor read address.
REQ-010 RDATA  output  6  storage contents at RADD.
REQ-011 RVALID  output  1  valid bit of entry RADD.
REQ-012 BUSY  output  1  high whenever state is not IDLE.
REQ-013 ACK  output  1  one-cycle pulse marking completion of a write or clear.
REQ-014 COUNT  output  7  number of valid entries, 0..64.

Function
REQ-015 Storage SHALL be 64 x 6-bit data plus a 64-bit valid bitmap, both held in flops.
REQ-016 The FSM SHALL have exactly these states: IDLE, WRITE, HOLD, DONE and SWEEP.
REQ-017 IDLE with CLRMEM=1 SHALL go to SWEEP, and CLRMEM SHALL win over a simultaneous WEN=1.
REQ-018 IDLE with WEN=1 and CLRMEM=0 SHALL latch ADD and DIN on that edge and go to WRITE.
REQ-019 WEN, ADD, DIN and CLRMEM SHALL be ignored outside IDLE, with no queuing of requests.
REQ-020 On the edge that leaves WRITE, the block SHALL set mem[latched ADD] to the latched DIN, set the matching valid bit, and go to HOLD.
REQ-021 COUNT SHALL increment by 1 on a write only if the target valid bit was 0; rewriting a valid entry SHALL leave COUNT unchanged.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles using a 4-bit counter, then go to DONE.
REQ-023 DONE SHALL last one cycle with ACK=1, then go to IDLE.
REQ-024 Write latency: WEN is sampled at edge k and ACK is high for the cycle following edge k+1+HOLD_CYCLES.
REQ-025 BUSY SHALL be 1 from edge k+1 through the ACK cycle.
REQ-026 SWEEP SHALL step a 6-bit index 0..63, clearing one entry per cycle (data to 0, valid bit to 0).
REQ-027 After clearing index 63, SWEEP SHALL go to DONE, and COUNT SHALL be 0 from that edge.
REQ-028 A clear SHALL take 64 SWEEP cycles plus 1 DONE cycle.
REQ-029 RDATA and RVALID SHALL be combinational from storage.
REQ-030 When RADD equals the address being written, RDATA SHALL show the new value from the commit edge onward, with no bypass before it.
REQ-031 ACK and BUSY SHALL be registered, i.e. decoded from registered state with no input-to-output combinational path.
REQ-032 COUNT SHALL never exceed 64 and never underflow.

Reset
REQ-033 RST=0 SHALL, asynchronously, force state to IDLE and set the HOLD counter, sweep index, COUNT, ACK and BUSY to 0.
REQ-034 RST=0 SHALL clear all 64 valid bits, so RVALID=0, and set all data entries to 0, so RDATA=0.
REQ-035 Reset asserted mid-WRITE, mid-HOLD or mid-SWEEP SHALL abort the operation with no ACK.
REQ-036 After RST returns to 1, the first request SHALL be sampled on the first rising edge.

Verification
REQ-037 Scenario: reset, WEN=1 with ADD=5 and DIN=42 for one cycle -> ACK high 6 cycles later (HOLD_CYCLES=4), COUNT=1, RADD=5 gives RDATA=42 and RVALID=1.
REQ-038 Scenario: during BUSY apply WEN=1 with ADD=6 and DIN=9 -> ignored, so RADD=6 gives RVALID=0 and COUNT is unchanged.
REQ-039 Scenario: write ADD=5 twice, with DIN=42 then DIN=7 -> COUNT stays 1 and RDATA=7.
REQ-040 Scenario: write addresses 0..63, then CLRMEM=1 -> ACK after 65 cycles, COUNT=0, every RADD gives RVALID=0.
REQ-041 Scenario: WEN=1 and CLRMEM=1 in the same IDLE cycle -> SWEEP taken and the write discarded.
REQ-042 Scenario: RST=0 in the second HOLD cycle -> BUSY=0 and COUNT=0 immediately, and no ACK is produced.
